// File: rtl/mac_pkg.sv
// Shared helpers for the MAC array: beat-counter sizing, lane packing offsets and
// the width-generic saturating adder used by every lane.
package mac_pkg;

    localparam int unsigned MAX_W = 64;

    function automatic int unsigned cnt_width(input int unsigned len);
        return (len <= 32'd2) ? 32'd1 : $clog2(len);
    endfunction

    function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

    // Operands arrive already extended to MAX_W; result is {ovf, value}, value valid in [w-1:0].
    function automatic logic [MAX_W:0] sat_add(
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b,
        input int unsigned      w,
        input logic             sgn,
        input logic             sat
    );
        logic [MAX_W-1:0] sum;
        logic [MAX_W-1:0] umax;
        logic [MAX_W-1:0] smax;
        logic [MAX_W-1:0] smin;
        logic [MAX_W-1:0] res;
        logic             ovf;
        sum  = a + b;
        umax = (64'd1 << w) - 64'd1;
        smax = (64'd1 << (w - 32'd1)) - 64'd1;
        smin = ~smax;
        if (sgn) begin
            ovf = ($signed(sum) > $signed(smax)) || ($signed(sum) < $signed(smin));
            if (sat && ovf) begin
                res = sum[MAX_W-1] ? smin : smax;
            end else begin
                res = sum;
            end
        end else begin
            ovf = (sum > umax);
            if (sat && ovf) begin
                res = umax;
            end else begin
                res = sum;
            end
        end
        return {ovf, res};
    endfunction

endpackage

// File: rtl/mac_array_lane.sv
// One MAC lane: product register, accumulator with optional saturation, sticky
// per-window overflow and the lane's slice of the result register.
module mac_array_lane
    import mac_pkg::*;
#(
    parameter int IN_WIDTH  = 8,
    parameter int ACC_WIDTH = 22,
    parameter int SIGNED    = 0,
    parameter int SATURATE  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_clear,
    input  logic                 i_accept,
    input  logic                 i_take,
    input  logic                 i_last,
    input  logic [IN_WIDTH-1:0]  i_img,
    input  logic [IN_WIDTH-1:0]  i_wt,
    output logic [ACC_WIDTH-1:0] o_data,
    output logic                 o_ovf
);

    localparam int PW = 2 * IN_WIDTH;
    localparam logic SGN = (SIGNED != 0);
    localparam logic SAT = (SATURATE != 0);

    logic [PW-1:0]        w_img_x;
    logic [PW-1:0]        w_wt_x;
    logic [PW-1:0]        w_prod;
    logic [MAX_W-1:0]     w_prod_x;
    logic [MAX_W-1:0]     w_acc_x;
    logic [MAX_W:0]       w_sat;
    logic [ACC_WIDTH-1:0] w_res;
    logic                 w_ovf;
    logic [MAX_W-ACC_WIDTH-1:0] w_unused_hi;

    logic [PW-1:0]        r_prod;
    logic [ACC_WIDTH-1:0] r_acc;
    logic                 r_ovf_acc;

    // Extending both operands to PW bits makes the modular product correct for either signedness.
    assign w_img_x  = {{IN_WIDTH{SGN & i_img[IN_WIDTH-1]}}, i_img};
    assign w_wt_x   = {{IN_WIDTH{SGN & i_wt[IN_WIDTH-1]}}, i_wt};
    assign w_prod   = w_img_x * w_wt_x;

    assign w_prod_x = {{(MAX_W-PW){SGN & r_prod[PW-1]}}, r_prod};
    assign w_acc_x  = {{(MAX_W-ACC_WIDTH){SGN & r_acc[ACC_WIDTH-1]}}, r_acc};
    assign w_sat    = sat_add(w_acc_x, w_prod_x, ACC_WIDTH, SGN, SAT);
    assign w_res    = w_sat[ACC_WIDTH-1:0];
    assign w_ovf    = w_sat[MAX_W];
    assign w_unused_hi = w_sat[MAX_W-1:ACC_WIDTH];

    // Product capture and accumulation; acc returns to 0 after each window so the next starts clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod    <= {PW{1'b0}};
            r_acc     <= {ACC_WIDTH{1'b0}};
            r_ovf_acc <= 1'b0;
            o_data    <= {ACC_WIDTH{1'b0}};
            o_ovf     <= 1'b0;
        end else if (i_clear) begin
            r_acc     <= {ACC_WIDTH{1'b0}};
            r_ovf_acc <= 1'b0;
        end else begin
            if (i_accept) begin
                r_prod <= w_prod;
            end
            if (i_take) begin
                if (i_last) begin
                    o_data    <= w_res;
                    o_ovf     <= r_ovf_acc | w_ovf;
                    r_acc     <= {ACC_WIDTH{1'b0}};
                    r_ovf_acc <= 1'b0;
                end else begin
                    r_acc     <= w_res;
                    r_ovf_acc <= r_ovf_acc | w_ovf;
                end
            end
        end
    end

endmodule

// File: rtl/mac_array.sv
// NUM_LANES parallel multiply-accumulate lanes sharing one beat counter, a
// two-stage pipeline and a single valid/ready result register.
module mac_array
    import mac_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int IN_WIDTH  = 8,
    parameter int ACC_WIDTH = 22,
    parameter int ACC_LEN   = 9,
    parameter int SIGNED    = 0,
    parameter int SATURATE  = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_LANES*IN_WIDTH-1:0]  img_in,
    input  logic [NUM_LANES*IN_WIDTH-1:0]  weight_in,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_LANES*ACC_WIDTH-1:0] out_data,
    output logic [NUM_LANES-1:0]           out_ovf
);

    localparam int CW = cnt_width(ACC_LEN);

    logic [CW-1:0] r_beat_cnt;
    logic          r_p_valid;
    logic          r_p_last;
    logic          r_out_valid;
    logic          w_cnt_last;
    logic          w_stall;
    logic          w_accept;
    logic          w_take;

    // Only a finished window that cannot leave the pipeline blocks it.
    assign w_stall    = r_p_valid & r_p_last & r_out_valid & ~out_ready;
    assign in_ready   = ~clear & ~w_stall;
    assign w_accept   = in_valid & in_ready;
    assign w_take     = r_p_valid & ~w_stall & ~clear;
    assign w_cnt_last = (r_beat_cnt == CW'(ACC_LEN - 1));
    assign out_valid  = r_out_valid;

    // Beat counter, stage-1 valid/last flags and the result-valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt  <= {CW{1'b0}};
            r_p_valid   <= 1'b0;
            r_p_last    <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (clear) begin
            r_beat_cnt  <= {CW{1'b0}};
            r_p_valid   <= 1'b0;
            r_p_last    <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_p_valid  <= 1'b1;
                r_p_last   <= w_cnt_last;
                r_beat_cnt <= w_cnt_last ? {CW{1'b0}} : r_beat_cnt + CW'(1);
            end else if (w_take) begin
                r_p_valid  <= 1'b0;
            end
            if (w_take && r_p_last) begin
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        mac_array_lane #(
            .IN_WIDTH (IN_WIDTH),
            .ACC_WIDTH(ACC_WIDTH),
            .SIGNED   (SIGNED),
            .SATURATE (SATURATE)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_clear (clear),
            .i_accept(w_accept),
            .i_take  (w_take),
            .i_last  (r_p_last),
            .i_img   (img_in[lane_lo(g, IN_WIDTH) +: IN_WIDTH]),
            .i_wt    (weight_in[lane_lo(g, IN_WIDTH) +: IN_WIDTH]),
            .o_data  (out_data[lane_lo(g, ACC_WIDTH) +: ACC_WIDTH]),
            .o_ovf   (out_ovf[g])
        );
    end

endmodule
